// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one outstanding load/store,
// fixed wait-state latency, byte-lane stores and range/alignment errors.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic [31:0] acc_hi;
  logic        acc_err;
  logic [AW-1:0] acc_idx;

  assign accept     = (state == S_IDLE) && req_valid;
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign mem_stall  = accept || (state == S_WAIT) || ((state == S_RESP) && !resp_ready);

  // With zero wait states the commit happens on the accept edge, before the
  // latch holds the request, so the access fields come straight from the port.
  assign acc_we    = (state == S_IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
  assign acc_be    = (state == S_IDLE) ? req_be    : lat_be;
  assign acc_hi    = acc_addr >> (AW + 2);
  assign acc_err   = (acc_hi != 32'd0) || (acc_addr[1:0] != 2'b00);
  assign acc_idx   = acc_addr[AW+1:2];

  assign commit = rst_n && (((state == S_WAIT) && (cnt == 4'd0)) ||
                            (accept && (WAIT_STATES == 0)));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req_valid) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
      S_RESP: if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= CNT_INIT;
      else if ((state == S_WAIT) && (cnt != 4'd0))
        cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_we || acc_err) ? 32'd0 : mem[acc_idx];
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: WAIT_STATES=2 and WAIT_STATES=0 instances
// share the clock and reset; sel routes stimulus and observation to one of them.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        resp_ready = 1'b1;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_stall;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_stall;
  logic [31:0] b_resp_rdata;

  logic        rv, rrdy, rerr, stall;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(a_req_ready),
    .resp_valid(a_resp_valid), .resp_ready(sel ? 1'b1 : resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_stall(a_mem_stall)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .req_ready(b_req_ready),
    .resp_valid(b_resp_valid), .resp_ready(sel ? resp_ready : 1'b1),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_stall(b_mem_stall)
  );

  assign rv    = sel ? b_resp_valid : a_resp_valid;
  assign rrdy  = sel ? b_req_ready  : a_req_ready;
  assign rerr  = sel ? b_resp_err   : a_resp_err;
  assign stall = sel ? b_mem_stall  : a_mem_stall;
  assign rdata = sel ? b_resp_rdata : a_resp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access with resp_ready held high; returns response fields, the number
  // of cycles from the accept edge to resp_valid, and cycles with mem_stall high.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] od, output logic oe,
                        output int lat, output int nstall);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    resp_ready = 1'b1;
    #1;
    nstall = int'(stall);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    nstall += int'(stall);
    while (!rv && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      nstall += int'(stall);
    end
    od = rdata; oe = rerr;
    if (!rv) begin
      checks++; failures++;
      $display("FAIL resp_timeout observed=0 expected=1");
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat, ns;

  initial begin
    #2;
    chk("rst_req_ready", 32'(rrdy), 32'd1);
    chk("rst_resp_valid", 32'(rv), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(rerr), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, lat, ns);
    chk("st_latency", 32'(lat), 32'd2);
    chk("st_stall_cycles", 32'(ns), 32'd3);
    chk("st_err", 32'(e), 32'd0);
    chk("st_rdata_zero", d, 32'd0);

    access(1'b0, 32'h10, 32'd0, 4'h0, d, e, lat, ns);
    chk("ld_full", d, 32'hDEADBEEF);
    chk("ld_full_err", 32'(e), 32'd0);
    access(1'b1, 32'h10, 32'h000000AA, 4'b0001, d, e, lat, ns);
    access(1'b0, 32'h10, 32'd0, 4'h0, d, e, lat, ns);
    chk("ld_byte0", d, 32'hDEADBEAA);

    access(1'b1, 32'h0, 32'h01020304, 4'hF, d, e, lat, ns);
    access(1'b1, 32'h1000, 32'h55555555, 4'hF, d, e, lat, ns);
    chk("st_range_err", 32'(e), 32'd1);
    access(1'b0, 32'h0, 32'd0, 4'h0, d, e, lat, ns);
    chk("no_alias_write", d, 32'h01020304);
    access(1'b0, 32'h1000, 32'd0, 4'h0, d, e, lat, ns);
    chk("ld_range_err", 32'(e), 32'd1);
    chk("ld_range_rdata", d, 32'd0);
    access(1'b0, 32'h12, 32'd0, 4'h0, d, e, lat, ns);
    chk("ld_misalign_err", 32'(e), 32'd1);
    chk("ld_misalign_rdata", d, 32'd0);
    access(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, d, e, lat, ns);
    chk("st_misalign_err", 32'(e), 32'd1);
    access(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, d, e, lat, ns);
    chk("st_be0_err", 32'(e), 32'd0);
    access(1'b0, 32'h10, 32'd0, 4'h0, d, e, lat, ns);
    chk("ld_after_misalign_be0", d, 32'hDEADBEAA);

    // Back-pressure: response held for 5 cycles, stray requests ignored.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rv && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_resp_valid", 32'(rv), 32'd1);
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0]; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
      #1;
      chk("bp_hold_valid", 32'(rv), 32'd1);
      chk("bp_hold_rdata", rdata, 32'hDEADBEAA);
      chk("bp_hold_stall", 32'(stall), 32'd1);
      chk("bp_req_ready", 32'(rrdy), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    #1;
    chk("bp_release_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("bp_idle_valid", 32'(rv), 32'd0);
    chk("bp_idle_ready", 32'(rrdy), 32'd1);
    access(1'b0, 32'h10, 32'd0, 4'h0, d, e, lat, ns);
    chk("bp_stray_ignored", d, 32'hDEADBEAA);

    sel = 1'b1;
    access(1'b1, 32'h40, 32'h12345678, 4'hF, d, e, lat, ns);
    chk("ws0_st_latency", 32'(lat), 32'd0);
    chk("ws0_st_stall", 32'(ns), 32'd1);
    access(1'b0, 32'h40, 32'd0, 4'h0, d, e, lat, ns);
    chk("ws0_ld_latency", 32'(lat), 32'd0);
    chk("ws0_ld_data", d, 32'h12345678);
    sel = 1'b0;

    // Reset in the middle of a store's WAIT phase.
    access(1'b1, 32'h20, 32'h11111111, 4'hF, d, e, lat, ns);
    access(1'b0, 32'h20, 32'd0, 4'h0, d, e, lat, ns);
    chk("pre_rst_ld", d, 32'h11111111);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rv), 32'd0);
    chk("rst_mid_ready", 32'(rrdy), 32'd1);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_err", 32'(rerr), 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h20, 32'd0, 4'h0, d, e, lat, ns);
    chk("rst_discard_store", d, 32'h11111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
